// File: rtl/camera_capture_pack.sv
// -----------------------------------------------------------------------------
// camera_capture_pack
//
// Purpose:
//   Captures a DVP-style CMOS sensor stream (vsync / href / data) in the pixel
//   clock domain and packs IN_W-bit samples into OUT_W-bit words for the DDR
//   write FIFO. A configurable number of start-up frames is discarded after the
//   sensor register configuration reports completion. Words left incomplete at
//   the end of a line are flushed zero-padded, and frame/line status is
//   reported alongside the data path.
//
// Parameters:
//   IN_W        sample width per pclk
//   OUT_W       packed word width; must be a multiple of IN_W
//   SKIP_FRAMES frames discarded after init_done before capture (0..255)
//   VS_POL      vsync active level (1 = active-high)
//   MSB_FIRST   1: first sample of a word in the top lane; 0: in the bottom lane
//
// Ports:
//   camera_pclk      in   sole clock (pixel clock)
//   sys_rst          in   asynchronous, active-high reset
//   init_done        in   sensor configuration complete (other clock domain)
//   camera_vsync     in   frame sync
//   camera_href      in   line valid
//   camera_data      in   pixel sample, IN_W bits
//   ddr_wren         out  one-cycle write strobe
//   ddr_data_camera  out  packed word, valid with ddr_wren, held otherwise
//   frame_sync       out  one-cycle pulse per vsync leading edge while capturing
//   capture_active   out  high while in the CAPTURE state
//   line_count       out  lines completed in the current frame (saturating)
//   partial_flush    out  pulses with ddr_wren for a zero-padded partial word
//
// Optional build macro CAPTURE_STATS_EN adds:
//   frame_count      out  16-bit count of vsync leading edges seen in CAPTURE
//   last_frame_words out  32-bit write count of the frame that just ended
// -----------------------------------------------------------------------------
module camera_capture_pack #(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 64,
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1,
  parameter int MSB_FIRST   = 1
) (
  input  logic             camera_pclk,
  input  logic             sys_rst,
  input  logic             init_done,
  input  logic             camera_vsync,
  input  logic             camera_href,
  input  logic [IN_W-1:0]  camera_data,
  output logic             ddr_wren,
  output logic [OUT_W-1:0] ddr_data_camera,
  output logic             frame_sync,
  output logic             capture_active,
  output logic [15:0]      line_count,
  output logic             partial_flush
`ifdef CAPTURE_STATS_EN
  ,
  output logic [15:0]      frame_count,
  output logic [31:0]      last_frame_words
`endif
);

  // OUT_W % IN_W == 0 is a usage requirement; RATIO truncates otherwise.
  localparam int RATIO  = OUT_W / IN_W;
  localparam int FILL_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(RATIO - 1);
  localparam logic [7:0]        SKIP_LAST = 8'(SKIP_FRAMES);
  localparam logic              VS_ACTIVE = (VS_POL != 0);

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    SKIP      = 2'd1,
    CAPTURE   = 2'd2
  } state_e;

  state_e state_q;

  // init_done crosses in from the configuration domain.
  logic init_meta_q;
  logic init_s_q;

  // Registered copies of the sensor pins and their previous values for edge
  // detection.
  logic            vs_q;
  logic            vs_prev_q;
  logic            href_q;
  logic            href_prev_q;
  logic [IN_W-1:0] data_q;

  logic [FILL_W-1:0] fill_q;
  logic [OUT_W-1:0]  pack_q;
  logic [7:0]        skip_q;

  logic             wren_q;
  logic             pflush_q;
  logic             fsync_q;
  logic [OUT_W-1:0] wdata_q;
  logic [15:0]      line_q;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic vs_act;
  logic vs_lead;
  logic href_fall;
  logic abort;
  logic in_capture;
  logic sample_en;
  logic word_full;
  logic flush;
  logic wr_d;
  logic enter_capture;
  logic frame_lead;
  logic line_inc;

  assign vs_act    = (vs_q == VS_ACTIVE);
  assign vs_lead   = vs_act && (vs_prev_q != VS_ACTIVE);
  assign href_fall = href_prev_q && !href_q;

  // Losing init_s while active abandons everything in flight, including a
  // word that would otherwise complete on this very cycle.
  assign abort      = !init_s_q && (state_q != WAIT_INIT);
  assign in_capture = (state_q == CAPTURE) && !abort;

  assign sample_en = in_capture && href_q && !vs_act;
  assign word_full = sample_en && (fill_q == LAST_FILL);
  // href_q is low on a falling edge, so a flush never coincides with a sample.
  assign flush     = in_capture && href_fall && (fill_q != '0);
  assign wr_d      = word_full || flush;

  // The edge that moves SKIP into CAPTURE already counts as a capture frame
  // start for frame_sync and line_count.
  assign enter_capture = (state_q == SKIP) && !abort && vs_lead &&
                         (skip_q == SKIP_LAST);
  assign frame_lead    = enter_capture || (in_capture && vs_lead);
  assign line_inc      = in_capture && href_fall && (line_q != 16'hFFFF);

  // Packing register with the current sample merged into its lane. On a flush
  // no sample is merged, so this equals pack_q and serves both write kinds.
  logic [FILL_W-1:0] lane_sel;
  logic [OUT_W-1:0]  pack_d;

  // NOTE: every variable driven here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    lane_sel = (MSB_FIRST != 0) ? (LAST_FILL - fill_q) : fill_q;
    pack_d   = pack_q;
    if (sample_en) begin
      pack_d[int'(lane_sel)*IN_W +: IN_W] = data_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Input registers, control FSM and packing datapath
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge camera_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= WAIT_INIT;
      init_meta_q <= 1'b0;
      init_s_q    <= 1'b0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= '0;
      fill_q      <= '0;
      // NOTE: the packing register is a plain register, not a RAM, so it is
      // reset; a stale lane would otherwise leak into the first padded flush.
      pack_q      <= '0;
      skip_q      <= '0;
      wren_q      <= 1'b0;
      pflush_q    <= 1'b0;
      fsync_q     <= 1'b0;
      wdata_q     <= '0;
      line_q      <= '0;
    end else begin
      init_meta_q <= init_done;
      init_s_q    <= init_meta_q;
      vs_q        <= camera_vsync;
      vs_prev_q   <= vs_q;
      href_q      <= camera_href;
      href_prev_q <= href_q;
      data_q      <= camera_data;

      wren_q   <= wr_d;
      pflush_q <= flush;
      fsync_q  <= frame_lead;
      if (wr_d) begin
        wdata_q <= pack_d;
      end

      // A vsync edge wins over a same-cycle href fall: the flushed line
      // belongs to the frame that is ending.
      if (frame_lead) begin
        line_q <= '0;
      end else if (line_inc) begin
        line_q <= line_q + 16'd1;
      end

      if (abort) begin
        state_q <= WAIT_INIT;
        fill_q  <= '0;
        pack_q  <= '0;
        skip_q  <= '0;
      end else begin
        case (state_q)
          WAIT_INIT: begin
            skip_q <= '0;
            if (init_s_q) begin
              state_q <= SKIP;
            end
          end
          SKIP: begin
            if (vs_lead) begin
              skip_q <= skip_q + 8'd1;
              if (skip_q == SKIP_LAST) begin
                state_q <= CAPTURE;
              end
            end
          end
          CAPTURE: begin
            if (wr_d) begin
              pack_q <= '0;
              fill_q <= '0;
            end else if (sample_en) begin
              pack_q <= pack_d;
              fill_q <= fill_q + FILL_W'(1);
            end
          end
          default: state_q <= WAIT_INIT;
        endcase
      end
    end
  end

  assign ddr_wren        = wren_q;
  assign ddr_data_camera = wdata_q;
  assign frame_sync      = fsync_q;
  assign capture_active  = (state_q == CAPTURE);
  assign line_count      = line_q;
  assign partial_flush   = pflush_q;

`ifdef CAPTURE_STATS_EN
  // ---------------------------------------------------------------------------
  // Frame statistics. Counting uses the write decision rather than the
  // registered strobe so a write coinciding with vs_lead lands in the frame
  // that is ending.
  // ---------------------------------------------------------------------------
  logic [15:0] frame_cnt_q;
  logic [31:0] run_words_q;
  logic [31:0] last_words_q;
  logic [31:0] run_words_inc;

  assign run_words_inc = run_words_q + 32'(wr_d);

  always_ff @(posedge camera_pclk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_cnt_q  <= '0;
      run_words_q  <= '0;
      last_words_q <= '0;
    end else if (!in_capture) begin
      run_words_q <= '0;
    end else if (vs_lead) begin
      frame_cnt_q  <= frame_cnt_q + 16'd1;
      last_words_q <= run_words_inc;
      run_words_q  <= '0;
    end else begin
      run_words_q <= run_words_inc;
    end
  end

  assign frame_count      = frame_cnt_q;
  assign last_frame_words = last_words_q;
`endif

endmodule

// File: tb/tb_camera_capture_pack.sv
// -----------------------------------------------------------------------------
// Bench for camera_capture_pack. Three instances cover the default 8->64
// MSB-first path (SKIP_FRAMES=2), the LSB-first packing order, and a 16->32
// build with active-low vsync. The main instance's write stream is compared
// against a line-level packing model; a table of single lines and a few
// hand-written sequences cover the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_camera_capture_pack;

  localparam int SKIP_M = 2;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int          len;
    logic [7:0]  start;
    int          n_wr;
    logic [63:0] first_w;
    logic [63:0] last_w;
    logic        last_p;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: defaults, SKIP_FRAMES=2
  logic        m_init, m_vs, m_href;
  logic [7:0]  m_data;
  logic        m_wren, m_fs, m_cap, m_pf;
  logic [63:0] m_wdata;
  logic [15:0] m_lc;
  // LSB-first instance, SKIP_FRAMES=0
  logic        l_init, l_vs, l_href;
  logic [7:0]  l_data;
  logic        l_wren, l_fs, l_cap, l_pf;
  logic [63:0] l_wdata;
  logic [15:0] l_lc;
  // 16->32 instance, active-low vsync, SKIP_FRAMES=0
  logic        w_init, w_vs, w_href;
  logic [15:0] w_data;
  logic        w_wren, w_fs, w_cap, w_pf;
  logic [31:0] w_wdata;
  logic [15:0] w_lc;
`ifdef CAPTURE_STATS_EN
  logic [15:0] m_fc, l_fc, w_fc;
  logic [31:0] m_lw, l_lw, w_lw;
`endif

  camera_capture_pack #(.SKIP_FRAMES(SKIP_M)) u_main (
    .camera_pclk(clk), .sys_rst(rst), .init_done(m_init),
    .camera_vsync(m_vs), .camera_href(m_href), .camera_data(m_data),
    .ddr_wren(m_wren), .ddr_data_camera(m_wdata), .frame_sync(m_fs),
    .capture_active(m_cap), .line_count(m_lc), .partial_flush(m_pf)
`ifdef CAPTURE_STATS_EN
    , .frame_count(m_fc), .last_frame_words(m_lw)
`endif
  );

  camera_capture_pack #(.SKIP_FRAMES(0), .MSB_FIRST(0)) u_lsb (
    .camera_pclk(clk), .sys_rst(rst), .init_done(l_init),
    .camera_vsync(l_vs), .camera_href(l_href), .camera_data(l_data),
    .ddr_wren(l_wren), .ddr_data_camera(l_wdata), .frame_sync(l_fs),
    .capture_active(l_cap), .line_count(l_lc), .partial_flush(l_pf)
`ifdef CAPTURE_STATS_EN
    , .frame_count(l_fc), .last_frame_words(l_lw)
`endif
  );

  camera_capture_pack #(.IN_W(16), .OUT_W(32), .VS_POL(0), .SKIP_FRAMES(0)) u_w16 (
    .camera_pclk(clk), .sys_rst(rst), .init_done(w_init),
    .camera_vsync(w_vs), .camera_href(w_href), .camera_data(w_data),
    .ddr_wren(w_wren), .ddr_data_camera(w_wdata), .frame_sync(w_fs),
    .capture_active(w_cap), .line_count(w_lc), .partial_flush(w_pf)
`ifdef CAPTURE_STATS_EN
    , .frame_count(w_fc), .last_frame_words(w_lw)
`endif
  );

  // ---------------------------------------------------------------------------
  // Monitors (sample on the falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  logic [63:0] m_got_w [$];
  logic        m_got_p [$];
  int          m_fs_cnt;
  logic [63:0] l_got_w [$];
  logic        l_got_p [$];

  initial m_fs_cnt = 0;

  always @(negedge clk) begin
    if (m_wren) begin
      m_got_w.push_back(m_wdata);
      m_got_p.push_back(m_pf);
    end
    if (m_fs) m_fs_cnt++;
    if (l_wren) begin
      l_got_w.push_back(l_wdata);
      l_got_p.push_back(l_pf);
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model for the main instance: frame/line bookkeeping and packing
  // of each captured line into 8-byte words, first byte in the top lane.
  // ---------------------------------------------------------------------------
  logic [63:0] m_exp_w [$];
  logic        m_exp_p [$];
  int          m_edges;
  int          m_fs_exp;
  int          m_lines_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void model_line(input bq_t b);
    for (int i = 0; i < b.size(); i += 8) begin
      logic [63:0] w;
      int          n;
      w = '0;
      n = (b.size() - i < 8) ? b.size() - i : 8;
      for (int j = 0; j < n; j++) begin
        w = w | ({56'd0, b[i+j]} << (8 * (7 - j)));
      end
      m_exp_w.push_back(w);
      m_exp_p.push_back(n < 8);
    end
  endfunction

  task automatic drive_line(input bq_t b);
    foreach (b[k]) begin
      m_href = 1'b1;
      m_data = b[k];
      @(negedge clk);
    end
    m_href = 1'b0;
    m_data = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic m_line(input bq_t b);
    if (m_edges > SKIP_M) begin
      model_line(b);
      if (m_lines_exp < 16'hFFFF) m_lines_exp++;
    end
    drive_line(b);
  endtask

  task automatic m_vsync();
    m_vs = 1'b1;
    repeat (3) @(negedge clk);
    m_vs = 1'b0;
    repeat (3) @(negedge clk);
    m_edges++;
    if (m_edges > SKIP_M) begin
      m_lines_exp = 0;
      m_fs_exp++;
    end
  endtask

  task automatic m_compare(input string tag);
    int n;
    check($sformatf("%s_nwr", tag), 64'(m_got_w.size()), 64'(m_exp_w.size()));
    n = (m_got_w.size() < m_exp_w.size()) ? m_got_w.size() : m_exp_w.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_w%0d", tag, i), m_got_w[i], m_exp_w[i]);
      check($sformatf("%s_p%0d", tag, i), 64'(m_got_p[i]), 64'(m_exp_p[i]));
    end
    m_got_w.delete(); m_got_p.delete();
    m_exp_w.delete(); m_exp_p.delete();
  endtask

  function automatic bq_t ramp(input logic [7:0] start, input int len);
    bq_t b;
    for (int k = 0; k < len; k++) b.push_back(start + 8'(k));
    return b;
  endfunction

  task automatic l_line(input bq_t b);
    foreach (b[k]) begin
      l_href = 1'b1;
      l_data = b[k];
      @(negedge clk);
    end
    l_href = 1'b0;
    l_data = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic l_vsync();
    l_vs = 1'b1;
    repeat (3) @(negedge clk);
    l_vs = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vec_t tbl [5];
    bq_t  bytes;
    int   nl;

    m_edges = 0; m_fs_exp = 0; m_lines_exp = 0;
    rst = 1'b1;
    m_init = 0; m_vs = 0; m_href = 0; m_data = '0;
    l_init = 0; l_vs = 0; l_href = 0; l_data = '0;
    w_init = 0; w_vs = 1; w_href = 0; w_data = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_wren", 64'(m_wren), 64'd0);
    check("rst_wdata", m_wdata, 64'd0);
    check("rst_fsync", 64'(m_fs), 64'd0);
    check("rst_cap", 64'(m_cap), 64'd0);
    check("rst_lc", 64'(m_lc), 64'd0);
    check("rst_pf", 64'(m_pf), 64'd0);
    check("rst_w16_wdata", 64'(w_wdata), 64'd0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_init_cap", 64'(m_cap), 64'd0);
    m_init = 1; l_init = 1; w_init = 1;
    repeat (6) @(negedge clk);

    // Four frames of 8 lines x 16 ramp bytes; the first SKIP_M are discarded.
    for (int f = 1; f <= 4; f++) begin
      if (f == 4) check("lc_before_edge4", 64'(m_lc), 64'd8);
      m_vsync();
      check($sformatf("fsync_f%0d", f), 64'(m_fs_cnt), 64'(m_fs_exp));
      check($sformatf("cap_f%0d", f), 64'(m_cap), 64'(m_edges > SKIP_M));
      check($sformatf("lc_f%0d", f), 64'(m_lc), 64'd0);
      for (int l = 0; l < 8; l++) begin
        m_line(ramp(8'h00, 16));
        if (f == 3 && l == 0) begin
          check("f3_first_nwr", 64'(m_got_w.size()), 64'd2);
          if (m_got_w.size() == 2) begin
            check("f3_word0", m_got_w[0], 64'h0001020304050607);
            check("f3_word1", m_got_w[1], 64'h08090A0B0C0D0E0F);
          end
        end
        m_compare($sformatf("f%0d_l%0d", f, l));
      end
    end

    // Single-line table: full words, partial flushes, one-byte line.
    tbl[0] = '{11, 8'hA0, 2, 64'hA0A1A2A3A4A5A6A7, 64'hA8A9AA0000000000, 1'b1};
    tbl[1] = '{8,  8'h10, 1, 64'h1011121314151617, 64'h1011121314151617, 1'b0};
    tbl[2] = '{1,  8'hFF, 1, 64'hFF00000000000000, 64'hFF00000000000000, 1'b1};
    tbl[3] = '{16, 8'h30, 2, 64'h3031323334353637, 64'h38393A3B3C3D3E3F, 1'b0};
    tbl[4] = '{9,  8'h40, 2, 64'h4041424344454647, 64'h4800000000000000, 1'b1};
    for (int t = 0; t < 5; t++) begin
      m_got_w.delete(); m_got_p.delete();
      drive_line(ramp(tbl[t].start, tbl[t].len));
      m_lines_exp++;
      check($sformatf("tbl%0d_nwr", t), 64'(m_got_w.size()), 64'(tbl[t].n_wr));
      if (m_got_w.size() > 0) begin
        check($sformatf("tbl%0d_first", t), m_got_w[0], tbl[t].first_w);
        check($sformatf("tbl%0d_last", t), m_got_w[m_got_w.size()-1], tbl[t].last_w);
        check($sformatf("tbl%0d_pf", t), 64'(m_got_p[m_got_p.size()-1]), 64'(tbl[t].last_p));
      end
      check($sformatf("tbl%0d_lc", t), 64'(m_lc), 64'(m_lines_exp));
    end
    m_got_w.delete(); m_got_p.delete();

    // Randomised frames against the model.
    for (int r = 0; r < 3; r++) begin
      m_vsync();
      nl = $urandom_range(4, 1);
      for (int l = 0; l < nl; l++) begin
        bytes = {};
        for (int k = 0; k < int'($urandom_range(30, 1)); k++) bytes.push_back(8'($urandom));
        m_line(bytes);
        m_compare($sformatf("rnd%0d_l%0d", r, l));
      end
      check($sformatf("rnd%0d_lc", r), 64'(m_lc), 64'(m_lines_exp));
      check($sformatf("rnd%0d_fs", r), 64'(m_fs_cnt), 64'(m_fs_exp));
    end

    // href fall and vsync leading edge registered on the same cycle.
    bytes = ramp(8'hC1, 5);
    foreach (bytes[k]) begin
      m_href = 1'b1;
      m_data = bytes[k];
      @(negedge clk);
    end
    m_href = 1'b0; m_data = '0; m_vs = 1'b1;
    repeat (3) @(negedge clk);
    m_vs = 1'b0;
    repeat (3) @(negedge clk);
    model_line(bytes);
    m_edges++; m_fs_exp++; m_lines_exp = 0;
    m_compare("coinc");
    check("coinc_lc", 64'(m_lc), 64'd0);
    check("coinc_fs", 64'(m_fs_cnt), 64'(m_fs_exp));

    // init_done drops mid-line: the partial word is discarded.
    bytes = ramp(8'h51, 5);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) m_init = 1'b0;
      m_href = 1'b1;
      m_data = bytes[k];
      @(negedge clk);
    end
    m_href = 1'b0; m_data = '0;
    repeat (6) @(negedge clk);
    m_compare("drop");
    check("drop_cap", 64'(m_cap), 64'd0);
    m_init = 1'b1;
    repeat (6) @(negedge clk);
    m_edges = 0;
    for (int e = 1; e <= SKIP_M + 1; e++) begin
      m_vsync();
      m_line(ramp(8'h00, 16));
      m_compare($sformatf("reinit_e%0d", e));
      check($sformatf("reinit_cap%0d", e), 64'(m_cap), 64'(e > SKIP_M));
    end

    // LSB-first packing order.
    l_vsync();
    l_got_w.delete(); l_got_p.delete();
    l_line('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    check("lsb_nwr", 64'(l_got_w.size()), 64'd1);
    if (l_got_w.size() > 0) begin
      check("lsb_word", l_got_w[0], 64'h8877665544332211);
      check("lsb_pf", 64'(l_got_p[0]), 64'd0);
    end
    l_got_w.delete(); l_got_p.delete();
    l_line('{8'h01, 8'h02, 8'h03});
    check("lsb_part_nwr", 64'(l_got_w.size()), 64'd1);
    if (l_got_w.size() > 0) begin
      check("lsb_part_word", l_got_w[0], 64'h0000000000030201);
      check("lsb_part_pf", 64'(l_got_p[0]), 64'd1);
    end

`ifdef CAPTURE_STATS_EN
    // Entry edge is not itself a frame end; the next edge closes a 2-word frame.
    l_vsync();
    check("stats_fc1", 64'(l_fc), 64'd1);
    check("stats_lw1", 64'(l_lw), 64'd2);
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 4; l++) l_line(ramp(8'(f * 40), 40));
      l_vsync();
    end
    check("stats_fc4", 64'(l_fc), 64'd4);
    check("stats_lw4", 64'(l_lw), 64'd20);
`endif

    // 16->32 with active-low vsync: latency from the second sample's pins.
    w_vs = 1'b0;
    repeat (3) @(negedge clk);
    w_vs = 1'b1;
    repeat (3) @(negedge clk);
    check("w16_cap", 64'(w_cap), 64'd1);
    w_href = 1'b1; w_data = 16'h1234;
    @(negedge clk);
    w_data = 16'h5678;
    check("w16_wren_n0", 64'(w_wren), 64'd0);
    @(negedge clk);
    w_href = 1'b0; w_data = '0;
    check("w16_wren_n1", 64'(w_wren), 64'd0);
    @(negedge clk);
    check("w16_wren_n2", 64'(w_wren), 64'd1);
    check("w16_word", 64'(w_wdata), 64'h12345678);
    check("w16_pf", 64'(w_pf), 64'd0);
    repeat (4) @(negedge clk);
    check("w16_hold", 64'(w_wdata), 64'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
